param_register_file: RTL and testbench

PARAM_REGISTER_FILE -- requirements
Module: param_register_file

---
 rtl/param_register_file.sv | 155 +++++++++++++++
 tb/tb_param_register_file.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/param_register_file.sv
// param_register_file
// Parameterised register file with two combinational read ports and one
// synchronous write port. After reset (synchronous, active-low rst) an
// initialisation sequencer walks every register and loads it with its own
// index. Reads return zero while that walk runs. Writes that arrive during
// the walk, or that target an unimplemented address, are discarded. Each
// discarded write produces a one-cycle wr_drop pulse on the next cycle.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> an accepted write is forwarded combinationally to any read
//                port addressing the same register in the same cycle.
//   undefined -> no forwarding; a read sees the old value until the edge.
module param_register_file #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 15,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] src_1,
    input  logic [ADDR_W-1:0] src_2,
    input  logic [ADDR_W-1:0] dest_wb,
    input  logic [DATA_W-1:0] result_wb,
    input  logic              write_back_en,
    output logic [DATA_W-1:0] reg1,
    output logic [DATA_W-1:0] reg2,
    output logic              busy,
    output logic              wr_drop
);

    // One extra bit so that NUM_REGS == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] cnt_reg;
    logic              busy_reg;
    logic              wr_drop_reg;

    // Register storage. It has no reset value; the INIT walk is the only
    // initialisation.
    logic [DATA_W-1:0] registers [NUM_REGS];

    logic              dest_valid;
    logic              wb_accept;
    logic              wb_drop;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    // Classify the incoming write request as accepted, dropped, or absent.
    always_comb begin
        dest_valid = ({1'b0, dest_wb} < NUM_REGS_W);
        wb_accept  = write_back_en && dest_valid && (state_reg == READY);
        wb_drop    = write_back_en && ((state_reg == INIT) || !dest_valid);
    end

    // Pick the single write source: the INIT walk or an accepted write-back.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = dest_wb;
        wr_data = result_wb;
        if (state_reg == INIT) begin
            wr_en   = 1'b1;
            wr_addr = cnt_reg;
            wr_data = DATA_W'(cnt_reg);
        end else if (wb_accept) begin
            wr_en = 1'b1;
        end
    end

    // Sequencer FSM: reset forces INIT, and INIT walks cnt up to the last
    // index before it moves to READY.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= INIT;
            cnt_reg     <= '0;
            busy_reg    <= 1'b1;
            wr_drop_reg <= 1'b0;
        end else begin
            wr_drop_reg <= wb_drop;
            case (state_reg)
                INIT: begin
                    if (cnt_reg == LAST_IDX) begin
                        state_reg <= READY;
                        busy_reg  <= 1'b0;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                READY: begin
                    busy_reg <= 1'b0;
                end
                default: begin
                    state_reg <= INIT;
                    busy_reg  <= 1'b1;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    // Storage write. Contents are frozen while rst is held low.
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            registers[wr_addr] <= wr_data;
        end
    end

    assign busy    = busy_reg;
    assign wr_drop = wr_drop_reg;

    // Two identical read ports, generated from one template.
    logic [ADDR_W-1:0] rd_addr [2];
    assign rd_addr[0] = src_1;
    assign rd_addr[1] = src_2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic              src_valid;
            logic              fwd;
            logic [DATA_W-1:0] rd_val;

            assign src_valid = ({1'b0, rd_addr[gi]} < NUM_REGS_W);
`ifdef REGFILE_BYPASS_EN
            // Only accepted writes are forwarded; dropped writes never are.
            assign fwd = wb_accept && (rd_addr[gi] == dest_wb);
`else
            assign fwd = 1'b0;
`endif
            // Read mux: zero while busy or when the address is out of range.
            always_comb begin
                rd_val = '0;
                if (!busy_reg && src_valid) begin
                    if (fwd) begin
                        rd_val = result_wb;
                    end else begin
                        rd_val = registers[rd_addr[gi]];
                    end
                end
            end
        end
    endgenerate

    assign reg1 = g_rd[0].rd_val;
    assign reg2 = g_rd[1].rd_val;

endmodule

// File: tb/tb_param_register_file.sv
// Directed testbench for param_register_file (default parameters).
module tb_param_register_file;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 15;
    localparam int ADDR_W   = 4;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] src_1;
    logic [ADDR_W-1:0] src_2;
    logic [ADDR_W-1:0] dest_wb;
    logic [DATA_W-1:0] result_wb;
    logic              write_back_en;
    logic [DATA_W-1:0] reg1;
    logic [DATA_W-1:0] reg2;
    logic              busy;
    logic              wr_drop;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [DATA_W-1:0] exp_regs [NUM_REGS];

    param_register_file #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .src_1        (src_1),
        .src_2        (src_2),
        .dest_wb      (dest_wb),
        .result_wb    (result_wb),
        .write_back_en(write_back_en),
        .reg1         (reg1),
        .reg2         (reg2),
        .busy         (busy),
        .wr_drop      (wr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count INIT cycles (busy high at successive negedges), bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        write_back_en = 1'b1; dest_wb = 4'd1; result_wb = 32'h1111;
        src_1 = 4'd0; src_2 = 4'd1;
        repeat (3) @(negedge clk);
        write_back_en = 1'b0;
        #1;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL reset_busy got %0h want 1", busy);
        else pass_cnt++;
        total_cnt++;
        if (wr_drop !== 1'b0) $display("FAIL reset_wr_drop got %0h want 0", wr_drop);
        else pass_cnt++;
        total_cnt++;
        if (reg1 !== 32'h0) $display("FAIL reset_reg1 got %0h want 0", reg1);
        else pass_cnt++;
        $display("txn reset: busy=%0h wr_drop=%0h reg1=%0h", busy, wr_drop, reg1);
    endtask

    task automatic test_init;
        int n;
        rst = 1'b1;
        count_busy(n);
        total_cnt++;
        if (n !== NUM_REGS) $display("FAIL init_length got %0d want %0d", n, NUM_REGS);
        else pass_cnt++;
        for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = DATA_W'(i);
        src_1 = 4'd7; src_2 = 4'd14;
        #1;
        total_cnt++;
        if (reg1 !== 32'd7) $display("FAIL init_r7 got %0h want 7", reg1);
        else pass_cnt++;
        total_cnt++;
        if (reg2 !== 32'd14) $display("FAIL init_r14 got %0h want e", reg2);
        else pass_cnt++;
        src_1 = 4'd15;
        #1;
        total_cnt++;
        if (reg1 !== 32'd0) $display("FAIL read_oob got %0h want 0", reg1);
        else pass_cnt++;
        $display("txn init: busy_cycles=%0d", n);
    endtask

    task automatic test_write_read;
        @(negedge clk);
        write_back_en = 1'b1; dest_wb = 4'd3; result_wb = 32'hDEADBEEF;
        @(negedge clk);
        write_back_en = 1'b0;
        exp_regs[3] = 32'hDEADBEEF;
        src_1 = 4'd3; src_2 = 4'd3;
        #1;
        total_cnt++;
        if (reg1 !== 32'hDEADBEEF) $display("FAIL wr_r3_port1 got %0h want deadbeef", reg1);
        else pass_cnt++;
        total_cnt++;
        if (reg2 !== 32'hDEADBEEF) $display("FAIL wr_r3_port2 got %0h want deadbeef", reg2);
        else pass_cnt++;
        total_cnt++;
        if (wr_drop !== 1'b0) $display("FAIL wr_r3_nodrop got %0h want 0", wr_drop);
        else pass_cnt++;
        $display("txn write r3: reg1=%0h reg2=%0h", reg1, reg2);
    endtask

    task automatic test_same_cycle;
        logic [DATA_W-1:0] exp_now;
`ifdef REGFILE_BYPASS_EN
        exp_now = 32'h55;
`else
        exp_now = 32'd5;
`endif
        @(negedge clk);
        write_back_en = 1'b1; dest_wb = 4'd5; result_wb = 32'h55;
        src_1 = 4'd5; src_2 = 4'd4;
        #1;
        total_cnt++;
        if (reg1 !== exp_now) $display("FAIL same_cycle_before got %0h want %0h", reg1, exp_now);
        else pass_cnt++;
        total_cnt++;
        if (reg2 !== 32'd4) $display("FAIL same_cycle_other got %0h want 4", reg2);
        else pass_cnt++;
        @(negedge clk);
        write_back_en = 1'b0;
        exp_regs[5] = 32'h55;
        #1;
        total_cnt++;
        if (reg1 !== 32'h55) $display("FAIL same_cycle_after got %0h want 55", reg1);
        else pass_cnt++;
        $display("txn same-cycle r5: before=%0h after=%0h", exp_now, reg1);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            write_back_en = 1'b1; dest_wb = ADDR_W'(8 + i);
            result_wb = 32'hA0 + DATA_W'(i);
            exp_regs[8 + i] = 32'hA0 + DATA_W'(i);
        end
        @(negedge clk);
        write_back_en = 1'b0;
        for (int i = 0; i < 4; i += 2) begin
            src_1 = ADDR_W'(8 + i); src_2 = ADDR_W'(9 + i);
            #1;
            total_cnt++;
            if (reg1 !== exp_regs[8 + i]) $display("FAIL b2b_r%0d got %0h want %0h", 8 + i, reg1, exp_regs[8 + i]);
            else pass_cnt++;
            total_cnt++;
            if (reg2 !== exp_regs[9 + i]) $display("FAIL b2b_r%0d got %0h want %0h", 9 + i, reg2, exp_regs[9 + i]);
            else pass_cnt++;
            $display("txn b2b read: r%0d=%0h r%0d=%0h", 8 + i, reg1, 9 + i, reg2);
        end
    endtask

    task automatic test_drop_oob;
        @(negedge clk);
        write_back_en = 1'b1; dest_wb = 4'd15; result_wb = 32'h1234;
        src_1 = 4'd15; src_2 = 4'd0;
        #1;
        total_cnt++;
        if (reg1 !== 32'd0) $display("FAIL drop_no_fwd got %0h want 0", reg1);
        else pass_cnt++;
        @(negedge clk);
        write_back_en = 1'b0;
        total_cnt++;
        if (wr_drop !== 1'b1) $display("FAIL drop_oob_pulse got %0h want 1", wr_drop);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (wr_drop !== 1'b0) $display("FAIL drop_oob_clear got %0h want 0", wr_drop);
        else pass_cnt++;
        for (int i = 0; i < NUM_REGS; i++) begin
            src_1 = ADDR_W'(i);
            #1;
            total_cnt++;
            if (reg1 !== exp_regs[i]) $display("FAIL drop_unchanged_r%0d got %0h want %0h", i, reg1, exp_regs[i]);
            else pass_cnt++;
        end
        $display("txn drop oob: dest=15 registers swept");
    endtask

    task automatic test_reset_mid_init;
        int n;
        @(negedge clk);
        write_back_en = 1'b1; dest_wb = 4'd2; result_wb = 32'hAA;
        @(negedge clk);
        write_back_en = 1'b0; src_1 = 4'd2;
        #1;
        total_cnt++;
        if (reg1 !== 32'hAA) $display("FAIL mid_r2_written got %0h want aa", reg1);
        else pass_cnt++;
        // Reset from READY, then let INIT run to cnt=5.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        // Write during INIT: this edge also moves cnt to 6.
        write_back_en = 1'b1; dest_wb = 4'd2; result_wb = 32'hFF;
        @(negedge clk);
        write_back_en = 1'b0;
        total_cnt++;
        if (wr_drop !== 1'b1) $display("FAIL init_drop_pulse got %0h want 1", wr_drop);
        else pass_cnt++;
        // One reset edge at cnt=6.
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (wr_drop !== 1'b0) $display("FAIL mid_reset_drop got %0h want 0", wr_drop);
        else pass_cnt++;
        rst = 1'b1;
        count_busy(n);
        total_cnt++;
        if (n !== NUM_REGS) $display("FAIL mid_restart_length got %0d want %0d", n, NUM_REGS);
        else pass_cnt++;
        for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = DATA_W'(i);
        src_1 = 4'd2; src_2 = 4'd14;
        #1;
        total_cnt++;
        if (reg1 !== 32'd2) $display("FAIL mid_r2_restored got %0h want 2", reg1);
        else pass_cnt++;
        total_cnt++;
        if (reg2 !== 32'd14) $display("FAIL mid_r14 got %0h want e", reg2);
        else pass_cnt++;
        $display("txn reset mid-init: busy_cycles=%0d r2=%0h", n, reg1);
    endtask

    initial begin
        rst = 1'b0; src_1 = '0; src_2 = '0; dest_wb = '0;
        result_wb = '0; write_back_en = 1'b0;
        test_reset();
        test_init();
        test_write_read();
        test_same_cycle();
        test_back_to_back();
        test_drop_oob();
        test_reset_mid_init();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
